dma_fifo_sync: RTL and testbench
================================

// Module: dma_fifo_sync
// PURPOSE
//  Parametrised single-clock FIFO buffering words between the DMA engine and memory/peripheral ports.
//  Generalises the single-word DMA staging register to DEPTH words with full/empty/level status,
//  1-cycle registered read, flush, and sticky overflow/underflow error flags. Depth of 1 is not supported.
// PARAMETERS
//  WIDTH         16  data word width in bits
//  DEPTH         8   number of entries; power of two, >= 2
//  AFULL_LVL     6   almost_full asserted when count >= AFULL_LVL (1..DEPTH)
//  AEMPTY_LVL    1   almost_empty asserted when count <= AEMPTY_LVL (0..DEPTH-1)
// PORTS
//  clk           in   1             system clock, all state on rising edge
//  rst           in   1             asynchronous, active-low reset
//  flush         in   1             synchronous clear of contents and pointers
//  wr_en         in   1             write request
//  wr_data       in   WIDTH         write word
//  rd_en         in   1             read request
//  rd_data       out  WIDTH         read word, valid when rd_valid=1
//  rd_valid      out  1             one-cycle pulse, rd_data carries the accepted read
//  full          out  1             count == DEPTH
//  empty         out  1             count == 0
//  almost_full   out  1             count >= AFULL_LVL
//  almost_empty  out  1             count <= AEMPTY_LVL
//  count         out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
//  overflow      out  1             sticky: write attempted while full and not accepted
//  underflow     out  1             sticky: read attempted while empty
//  err_clr       in   1             clears overflow/underflow
// BEHAVIOUR
//  Reset (rst=0, async): pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0,
//   rd_valid=0, rd_data=0, overflow=0, underflow=0. Storage array not reset.
//  wr_acc = wr_en & (~full | rd_acc); rd_acc = rd_en & ~empty. No fall-through: a write to empty FIFO
//   cannot be read in the same cycle; it is readable from the next cycle.
//  Write: wr_acc stores wr_data at wr_ptr, wr_ptr+1. Read: rd_acc registers mem[rd_ptr] into rd_data,
//   rd_valid=1 in the next cycle (latency 1), rd_ptr+1. rd_data holds its last value when rd_valid=0 (never Z).
//  count next = count + wr_acc - rd_acc; simultaneous accepted read+write leaves count unchanged,
//   including when full (read frees slot, write fills it, full stays 1).
//  Status flags (full, empty, almost_*) are registered/derived from count, update the cycle after the op.
//  Pointers are $clog2(DEPTH)+1 bits; MSB is wrap bit; full = (addr equal & wrap differ), wrap is natural.
//  overflow set when wr_en & ~wr_acc; underflow set when rd_en & empty. Both sticky until err_clr;
//   set condition and err_clr in same cycle -> flag set (set wins).
//  flush (sync, highest priority): pointers=0, count=0, rd_valid=0 next cycle; wr_en/rd_en that cycle
//   ignored and do not raise error flags; error flags unaffected; rd_data holds.
//  rst asserted mid-operation: immediate return to reset state; in-flight rd_valid dropped.
// STRUCTURE
//  dma_fifo_defines.v (shared include): default WIDTH/DEPTH, pointer width macro, assertion guards.
//  Sub-module dma_fifo_mem: DEPTH x WIDTH array, one sync write port, one registered read port
//   (rd_data register lives here, reset to 0 by rst). Top holds pointers, count, flags, errors.
//  Elaboration check: DEPTH power of two, AFULL_LVL/AEMPTY_LVL within range, else $error.
// TESTING (WIDTH=16, DEPTH=8, AFULL_LVL=6, AEMPTY_LVL=1)
//  Write 0x0001..0x0008 -> full=1 after 8th, count=8, almost_full from count 6; 9th write -> overflow=1, data kept.
//  Read 8 words -> rd_data 0x0001..0x0008 in order, each 1 cycle after rd_en; empty=1; 9th read -> underflow=1.
//  Full FIFO, wr_en+rd_en same cycle with 0xBEEF -> count stays 8, full stays 1, no overflow, 0xBEEF read last.
//  Empty FIFO, wr_en+rd_en same cycle -> write accepted, rd_valid=0, underflow=1, count=1.
//  20 write/read pairs interleaved -> pointers wrap twice, data order preserved, count never >8.
//  Count=5, flush+wr_en -> count=0, empty=1, no write stored; rst low mid-read -> rd_valid=0, all flags reset.

Source files
------------

// File: rtl/dma_fifo_sync_pkg.sv
// Shared defaults and elaboration helpers for the DMA staging FIFO.
package dma_fifo_sync_pkg;

  localparam int DefWidth     = 16;
  localparam int DefDepth     = 8;
  localparam int DefAfullLvl  = 6;
  localparam int DefAemptyLvl = 1;

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/dma_fifo_mem.sv
// DEPTH x WIDTH storage with one synchronous write port and one registered read port.
module dma_fifo_mem
  import dma_fifo_sync_pkg::*;
#(
  parameter int WIDTH = DefWidth,
  parameter int DEPTH = DefDepth
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] storage [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      storage[wr_addr] <= wr_data;
    end
  end

  // When full, a simultaneous read and write hit the same slot; the read sees the old word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= storage[rd_addr];
    end
  end

endmodule

// File: rtl/dma_fifo_sync.sv
// Single-clock FIFO between the DMA engine and memory/peripheral ports, with level
// status, registered read, flush and sticky overflow/underflow flags.
module dma_fifo_sync
  import dma_fifo_sync_pkg::*;
#(
  parameter int WIDTH      = DefWidth,
  parameter int DEPTH      = DefDepth,
  parameter int AFULL_LVL  = DefAfullLvl,
  parameter int AEMPTY_LVL = DefAemptyLvl
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   err_clr
);

  localparam int AW = $clog2(DEPTH);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("dma_fifo_sync: DEPTH must be a power of two and at least 2");
  end
  if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
    $error("dma_fifo_sync: AFULL_LVL must lie in 1..DEPTH");
  end
  if (AEMPTY_LVL < 0 || AEMPTY_LVL > DEPTH - 1) begin : g_bad_aempty
    $error("dma_fifo_sync: AEMPTY_LVL must lie in 0..DEPTH-1");
  end

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count_next;
  logic        wr_acc;
  logic        rd_acc;
  logic        ovf_set;
  logic        unf_set;

  // Flush swallows both requests, so neither can be accepted nor flagged as an error.
  assign rd_acc  = rd_en & ~empty & ~flush;
  assign wr_acc  = wr_en & (~full | rd_acc) & ~flush;
  assign ovf_set = wr_en & ~wr_acc & ~flush;
  assign unf_set = rd_en & empty & ~flush;

  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign almost_full  = (count >= (AW+1)'(AFULL_LVL));
  assign almost_empty = (count <= (AW+1)'(AEMPTY_LVL));

  always_comb begin
    count_next = count + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count    <= count_next;
      rd_valid <= rd_acc;
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (unf_set) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end

  dma_fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr[AW-1:0]),
    .wr_data(wr_data),
    .rd_en  (rd_acc),
    .rd_addr(rd_ptr[AW-1:0]),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_dma_fifo_sync.sv
// Randomised scoreboard bench for dma_fifo_sync against a queue-based reference model.
module tb_dma_fifo_sync;

  localparam int WIDTH      = 16;
  localparam int DEPTH      = 8;
  localparam int AFULL_LVL  = 6;
  localparam int AEMPTY_LVL = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              wr_en = 1'b0;
  logic [WIDTH-1:0]  wr_data = '0;
  logic              rd_en = 1'b0;
  logic              err_clr = 1'b0;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [3:0]        count;
  logic              overflow;
  logic              underflow;

  logic [WIDTH-1:0]  mdl_q[$];
  logic [WIDTH-1:0]  exp_q[$];
  bit                mdl_valid = 1'b0;
  bit                mdl_ovf = 1'b0;
  bit                mdl_unf = 1'b0;
  logic [WIDTH-1:0]  mdl_last = '0;
  bit                racc;
  bit                wacc;
  int                checks = 0;
  int                passed = 0;

  dma_fifo_sync #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL), .AEMPTY_LVL(AEMPTY_LVL)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the FIFO contents are a plain queue, acceptance follows its occupancy.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdl_q.delete();
      exp_q.delete();
      mdl_valid = 1'b0;
      mdl_ovf   = 1'b0;
      mdl_unf   = 1'b0;
      mdl_last  = '0;
    end else if (flush) begin
      mdl_q.delete();
      mdl_valid = 1'b0;
      if (err_clr) begin
        mdl_ovf = 1'b0;
        mdl_unf = 1'b0;
      end
    end else begin
      racc = rd_en && (mdl_q.size() > 0);
      wacc = wr_en && ((mdl_q.size() < DEPTH) || racc);
      if (wr_en && !wacc) mdl_ovf = 1'b1;
      else if (err_clr) mdl_ovf = 1'b0;
      if (rd_en && mdl_q.size() == 0) mdl_unf = 1'b1;
      else if (err_clr) mdl_unf = 1'b0;
      if (racc) begin
        mdl_last = mdl_q.pop_front();
        exp_q.push_back(mdl_last);
      end
      if (wacc) mdl_q.push_back(wr_data);
      mdl_valid = racc;
    end
  end

  // Monitor: consumes expected reads when the DUT presents them and checks status every cycle.
  always @(negedge clk) begin
    logic [WIDTH-1:0] want;
    int               lvl;
    lvl = mdl_q.size();
    checkOutput("rd_valid", 32'(rd_valid), 32'(mdl_valid));
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("rd_unexpected", 32'(1), 32'(0));
      end else begin
        want = exp_q.pop_front();
        checkOutput("rd_data", 32'(rd_data), 32'(want));
      end
    end else begin
      checkOutput("rd_data_hold", 32'(rd_data), 32'(mdl_last));
    end
    checkOutput("count", 32'(count), 32'(lvl));
    checkOutput("full", 32'(full), 32'(lvl == DEPTH));
    checkOutput("empty", 32'(empty), 32'(lvl == 0));
    checkOutput("almost_full", 32'(almost_full), 32'(lvl >= AFULL_LVL));
    checkOutput("almost_empty", 32'(almost_empty), 32'(lvl <= AEMPTY_LVL));
    checkOutput("overflow", 32'(overflow), 32'(mdl_ovf));
    checkOutput("underflow", 32'(underflow), 32'(mdl_unf));
  end

  task automatic applyStimulus(input bit w, input logic [WIDTH-1:0] d, input bit r,
                               input bit f, input bit e);
    @(negedge clk);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    flush   = f;
    err_clr = e;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0009, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) applyStimulus(1'b1, WIDTH'($urandom), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(1);

    applyStimulus(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
    idle(1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
    idle(1);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, WIDTH'($urandom), 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, WIDTH'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, WIDTH'($urandom), 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0));
    end

    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, WIDTH'($urandom), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h0042, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(1);

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, WIDTH'($urandom), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h5555, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(2);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, WIDTH'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(3);

    @(negedge clk);
    #1 checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
